// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller that sequences I-cache reads, discards words from redirected fetches,
// holds the captured word while decode is stalled, and counts I-cache wait cycles.
module fetch_ctrl #(
  parameter int WAIT_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic                  icache_resp,
  input  logic [31:0]           icache_rdata,
  output logic                  icache_read,
  output logic [31:0]           icache_addr,
  output logic                  load_pc,
  output logic                  flush,
  output logic [31:0]           instruction,
  output logic                  if_valid,
  output logic [WAIT_CNT_W-1:0] miss_cycles
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_KILL  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  state_t                r_state;
  logic [31:0]           r_kill_addr;
  logic [31:0]           r_instruction;
  logic                  r_if_valid;
  logic [WAIT_CNT_W-1:0] r_miss_cycles;

  logic w_capture;
  logic w_miss;
  logic w_miss_sat;

  always_comb begin
    icache_read = 1'b1;
    icache_addr = pc;
    load_pc     = 1'b0;
    case (r_state)
      S_FETCH: load_pc = redirect | (icache_resp & ~stall);
      S_KILL: begin
        // A killed request must finish at its original address, whatever the PC does meanwhile.
        icache_addr = r_kill_addr;
        load_pc     = redirect;
      end
      S_HOLD: begin
        icache_read = 1'b0;
        load_pc     = redirect | ~stall;
      end
      default: load_pc = 1'b0;
    endcase
  end

  assign flush       = redirect;
  assign w_capture   = (r_state == S_FETCH) & icache_resp & ~redirect;
  assign w_miss      = icache_read & ~icache_resp;
  assign w_miss_sat  = &r_miss_cycles;

  assign instruction = r_instruction;
  assign if_valid    = r_if_valid;
  assign miss_cycles = r_miss_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_FETCH;
      r_kill_addr   <= 32'd0;
      r_instruction <= NOP_WORD;
      r_if_valid    <= 1'b0;
      r_miss_cycles <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (redirect && !icache_resp) begin
            r_state     <= S_KILL;
            r_kill_addr <= pc;
          end else if (icache_resp && !redirect && stall) begin
            r_state <= S_HOLD;
          end
        end
        S_KILL: begin
          if (icache_resp) begin
            r_state <= S_FETCH;
          end
        end
        S_HOLD: begin
          if (redirect || !stall) begin
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase

      if (w_capture) begin
        r_instruction <= icache_rdata;
      end
      // A redirect always wins: the word in IF/ID belongs to the wrong path.
      r_if_valid <= (w_capture | (r_if_valid & stall)) & ~redirect;

      if (w_miss && !w_miss_sat) begin
        r_miss_cycles <= r_miss_cycles + 1'b1;
      end
    end
  end

endmodule
